// File: rtl/apb_uart_master_if.sv
// apb_uart_master_if: APB bus between the requester and a UART completer
interface apb_uart_master_if;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PWRITE;
  logic        PSEL;
  logic        PENABLE;
  logic        PREADY;
  logic        PSLVERR;
  modport master (output PADDR, PWDATA, PWRITE, PSEL, PENABLE, input PRDATA, PREADY, PSLVERR);
  modport slave  (input PADDR, PWDATA, PWRITE, PSEL, PENABLE, output PRDATA, PREADY, PSLVERR);
endinterface

// File: rtl/apb_uart_master.sv
// apb_uart_master: single-outstanding command to APB requester with wait timeout
module apb_uart_master #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                      PCLK,
  input  logic                      PRESET,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_write,
  input  logic [31:0]               cmd_addr,
  input  logic [31:0]               cmd_wdata,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [31:0]               rsp_rdata,
  output logic                      rsp_err,
  output logic                      rsp_timeout,
  apb_uart_master_if.master         apb
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
  state_t state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [31:0] paddr, paddr_d, pwdata, pwdata_d, rdata_d;
  logic pwrite, pwrite_d, psel, psel_d, penable, penable_d;
  logic rv_d, err_d, to_d;
  assign cmd_ready = (state == IDLE) & ~PRESET;
  assign apb.PADDR = paddr;
  assign apb.PWDATA = pwdata;
  assign apb.PWRITE = pwrite;
  assign apb.PSEL = psel;
  assign apb.PENABLE = penable;
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state <= IDLE;
      cnt <= '0;
      paddr <= '0;
      pwdata <= '0;
      pwrite <= 1'b0;
      psel <= 1'b0;
      penable <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      state <= state_d;
      cnt <= cnt_d;
      paddr <= paddr_d;
      pwdata <= pwdata_d;
      pwrite <= pwrite_d;
      psel <= psel_d;
      penable <= penable_d;
      rsp_valid <= rv_d;
      rsp_rdata <= rdata_d;
      rsp_err <= err_d;
      rsp_timeout <= to_d;
    end
  end
  always_comb begin
    state_d = state;
    cnt_d = cnt;
    paddr_d = paddr;
    pwdata_d = pwdata;
    pwrite_d = pwrite;
    psel_d = psel;
    penable_d = penable;
    rv_d = rsp_valid;
    rdata_d = rsp_rdata;
    err_d = rsp_err;
    to_d = rsp_timeout;
    case (state)
      IDLE: if (cmd_valid) begin
        if (cmd_addr[1:0] == 2'b00) begin
          state_d = SETUP;
          psel_d = 1'b1;
          paddr_d = cmd_addr;
          pwrite_d = cmd_write;
          pwdata_d = cmd_write ? cmd_wdata : '0;
        end else begin
          state_d = RESP;
          rv_d = 1'b1;
          rdata_d = '0;
          err_d = 1'b1;
          to_d = 1'b0;
        end
      end
      SETUP: begin
        state_d = ACCESS;
        penable_d = 1'b1;
        cnt_d = '0;
      end
      ACCESS: if (apb.PREADY || cnt == CW'(TIMEOUT_CYCLES - 1)) begin
        state_d = RESP;
        psel_d = 1'b0;
        penable_d = 1'b0;
        rv_d = 1'b1;
        rdata_d = (apb.PREADY && !pwrite && !apb.PSLVERR) ? apb.PRDATA : '0;
        err_d = apb.PREADY ? apb.PSLVERR : 1'b1;
        to_d = ~apb.PREADY;
      end else begin
        cnt_d = cnt + CW'(1);
      end
      RESP: if (rsp_ready) begin
        state_d = IDLE;
        rv_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_apb_uart_master.sv
// tb_apb_uart_master: directed scenario checks of the APB requester
module tb_apb_uart_master;
  logic PCLK = 1'b0;
  logic PRESET, cmd_valid, cmd_write, rsp_ready;
  logic [31:0] cmd_addr, cmd_wdata;
  logic cmd_ready, rsp_valid, rsp_err, rsp_timeout;
  logic [31:0] rsp_rdata;
  int checks = 0;
  int errors = 0;
  apb_uart_master_if bus();
  apb_uart_master #(.TIMEOUT_CYCLES(8)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout), .apb(bus)
  );
  always #5 PCLK = ~PCLK;
  task automatic tick;
    @(negedge PCLK);
  endtask
  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr = a;
    cmd_wdata = d;
    tick();
    cmd_valid = 1'b0;
    cmd_wdata = 32'hFFFF_FFFF;
  endtask
  task automatic handshake;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask
  task automatic test_reset;
    PRESET = 1'b1;
    tick();
    tick();
    checks++;
    if ({cmd_ready, bus.PSEL, bus.PENABLE, bus.PWRITE, rsp_valid, rsp_err, rsp_timeout} !== 7'b0) begin
      errors++;
      $display("FAIL reset_ctrl got %b required 0000000", {cmd_ready, bus.PSEL, bus.PENABLE, bus.PWRITE, rsp_valid, rsp_err, rsp_timeout});
    end
    checks++;
    if ({bus.PADDR, bus.PWDATA, rsp_rdata} !== 96'b0) begin
      errors++;
      $display("FAIL reset_data got %h required 0", {bus.PADDR, bus.PWDATA, rsp_rdata});
    end
    PRESET = 1'b0;
    #1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready got %b required 1", cmd_ready);
    end
  endtask
  task automatic test_write;
    bus.PREADY = 1'b1;
    issue(1'b1, 32'h0C, 32'h83);
    checks++;
    if ({bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PADDR, bus.PWDATA, cmd_ready} !== {3'b101, 32'h0C, 32'h83, 1'b0}) begin
      errors++;
      $display("FAIL write_setup got %h required %h", {bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PADDR, bus.PWDATA, cmd_ready}, {3'b101, 32'h0C, 32'h83, 1'b0});
    end
    tick();
    checks++;
    if ({bus.PSEL, bus.PENABLE, rsp_valid} !== 3'b110) begin
      errors++;
      $display("FAIL write_access got %b required 110", {bus.PSEL, bus.PENABLE, rsp_valid});
    end
    tick();
    checks++;
    if ({bus.PSEL, bus.PENABLE, rsp_valid, rsp_err, rsp_timeout, rsp_rdata} !== {5'b00100, 32'h0}) begin
      errors++;
      $display("FAIL write_resp got %h required %h", {bus.PSEL, bus.PENABLE, rsp_valid, rsp_err, rsp_timeout, rsp_rdata}, {5'b00100, 32'h0});
    end
    handshake();
    checks++;
    if ({rsp_valid, cmd_ready} !== 2'b01) begin
      errors++;
      $display("FAIL write_done got %b required 01", {rsp_valid, cmd_ready});
    end
  endtask
  task automatic test_wait_read;
    bus.PREADY = 1'b0;
    bus.PRDATA = 32'h60;
    issue(1'b0, 32'h14, 32'h1234);
    checks++;
    if ({bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PWDATA} !== {3'b100, 32'h0}) begin
      errors++;
      $display("FAIL read_setup got %h required %h", {bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PWDATA}, {3'b100, 32'h0});
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if ({bus.PENABLE, bus.PADDR, rsp_valid} !== {1'b1, 32'h14, 1'b0}) begin
        errors++;
        $display("FAIL read_wait%0d got %h required %h", i, {bus.PENABLE, bus.PADDR, rsp_valid}, {1'b1, 32'h14, 1'b0});
      end
      if (i == 3) bus.PREADY = 1'b1;
    end
    tick();
    bus.PREADY = 1'b0;
    checks++;
    if ({bus.PENABLE, rsp_valid, rsp_err, rsp_timeout, rsp_rdata} !== {4'b0100, 32'h60}) begin
      errors++;
      $display("FAIL read_resp got %h required %h", {bus.PENABLE, rsp_valid, rsp_err, rsp_timeout, rsp_rdata}, {4'b0100, 32'h60});
    end
    handshake();
  endtask
  task automatic test_misaligned;
    bus.PREADY = 1'b1;
    issue(1'b0, 32'h0D, 32'h0);
    checks++;
    if ({bus.PSEL, rsp_valid, rsp_err, rsp_timeout, rsp_rdata} !== {4'b0110, 32'h0}) begin
      errors++;
      $display("FAIL misalign_resp got %h required %h", {bus.PSEL, rsp_valid, rsp_err, rsp_timeout, rsp_rdata}, {4'b0110, 32'h0});
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (bus.PSEL !== 1'b0) begin
        errors++;
        $display("FAIL misalign_psel got %b required 0", bus.PSEL);
      end
    end
    handshake();
  endtask
  task automatic test_slverr;
    bus.PREADY = 1'b1;
    bus.PSLVERR = 1'b1;
    bus.PRDATA = 32'h55;
    issue(1'b0, 32'h10, 32'h0);
    tick();
    tick();
    bus.PSLVERR = 1'b0;
    checks++;
    if ({rsp_valid, rsp_err, rsp_timeout, rsp_rdata} !== {3'b110, 32'h0}) begin
      errors++;
      $display("FAIL slverr_resp got %h required %h", {rsp_valid, rsp_err, rsp_timeout, rsp_rdata}, {3'b110, 32'h0});
    end
    handshake();
  endtask
  task automatic test_timeout;
    for (int k = 0; k < 2; k++) begin
      bus.PREADY = 1'b0;
      bus.PRDATA = 32'h77;
      issue(1'b0, 32'h20, 32'h0);
      for (int i = 0; i < 8; i++) begin
        tick();
        checks++;
        if (bus.PENABLE !== 1'b1) begin
          errors++;
          $display("FAIL timeout%0d_pen%0d got %b required 1", k, i, bus.PENABLE);
        end
        if (i == 7 && k == 1) bus.PREADY = 1'b1;
      end
      tick();
      bus.PREADY = 1'b0;
      checks++;
      if ({bus.PSEL, bus.PENABLE, rsp_valid, rsp_err, rsp_timeout, rsp_rdata} !== (k == 0 ? {5'b00111, 32'h0} : {5'b00100, 32'h77})) begin
        errors++;
        $display("FAIL timeout%0d_resp got %h required %h", k, {bus.PSEL, bus.PENABLE, rsp_valid, rsp_err, rsp_timeout, rsp_rdata}, (k == 0 ? {5'b00111, 32'h0} : {5'b00100, 32'h77}));
      end
      handshake();
    end
  endtask
  task automatic test_backpressure;
    bus.PREADY = 1'b1;
    bus.PRDATA = 32'hA5;
    issue(1'b0, 32'h08, 32'h0);
    tick();
    tick();
    bus.PRDATA = 32'h0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({rsp_valid, rsp_err, rsp_timeout, cmd_ready, rsp_rdata} !== {4'b1000, 32'hA5}) begin
        errors++;
        $display("FAIL hold%0d got %h required %h", i, {rsp_valid, rsp_err, rsp_timeout, cmd_ready, rsp_rdata}, {4'b1000, 32'hA5});
      end
      tick();
    end
    handshake();
    checks++;
    if ({rsp_valid, cmd_ready} !== 2'b01) begin
      errors++;
      $display("FAIL hold_release got %b required 01", {rsp_valid, cmd_ready});
    end
  endtask
  task automatic test_reset_mid;
    bus.PREADY = 1'b0;
    issue(1'b1, 32'h18, 32'h3C);
    tick();
    tick();
    PRESET = 1'b1;
    tick();
    checks++;
    if ({bus.PSEL, bus.PENABLE, bus.PWRITE, rsp_valid, rsp_err, rsp_timeout, cmd_ready, bus.PADDR, bus.PWDATA, rsp_rdata} !== 103'b0) begin
      errors++;
      $display("FAIL reset_mid got %h required 0", {bus.PSEL, bus.PENABLE, bus.PWRITE, rsp_valid, rsp_err, rsp_timeout, cmd_ready, bus.PADDR, bus.PWDATA, rsp_rdata});
    end
    PRESET = 1'b0;
    bus.PREADY = 1'b1;
    #1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_ready got %b required 1", cmd_ready);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if ({rsp_valid, bus.PSEL} !== 2'b00) begin
        errors++;
        $display("FAIL reset_mid_quiet%0d got %b required 00", i, {rsp_valid, bus.PSEL});
      end
    end
  endtask
  initial begin
    PRESET = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr = '0;
    cmd_wdata = '0;
    rsp_ready = 1'b0;
    bus.PREADY = 1'b0;
    bus.PSLVERR = 1'b0;
    bus.PRDATA = '0;
    test_reset();
    test_write();
    test_wait_read();
    test_misaligned();
    test_slverr();
    test_timeout();
    test_backpressure();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/apb_uart_master.md
APB_UART_MASTER -- requirements
Module: apb_uart_master

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 256: maximum ACCESS-phase cycles waited for PREADY before abort.
REQ-002 SHALL have port PCLK  input  1  sole clock, all logic on rising edge.
REQ-003 SHALL have port PRESET  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port cmd_valid  input  1  command request.
REQ-005 SHALL have port cmd_ready  output  1  command accepted when high with cmd_valid.
REQ-006 SHALL have port cmd_write  input  1  1=write, 0=read.
REQ-007 SHALL have port cmd_addr  input  32  byte address of the UART register.
REQ-008 SHALL have port cmd_wdata  input  32  write data.
REQ-009 SHALL have port rsp_valid  output  1  response available.
REQ-010 SHALL have port rsp_ready  input  1  response consumed when high with rsp_valid.
REQ-011 SHALL have port rsp_rdata  output  32  read data; 0 for writes and errors.
REQ-012 SHALL have port rsp_err  output  1  PSLVERR, timeout or misalignment.
REQ-013 SHALL have port rsp_timeout  output  1  error cause was timeout.
REQ-014 SHALL have ports PADDR out 32, PWDATA out 32, PWRITE out 1, PSEL out 1, PENABLE out 1: APB requester outputs.
REQ-015 SHALL have ports PRDATA in 32, PREADY in 1, PSLVERR in 1: APB completer responses.

Function
REQ-016 SHALL implement FSM states IDLE, SETUP, ACCESS, RESP, with all APB and rsp outputs registered.
REQ-017 SHALL drive cmd_ready high only in IDLE; at most one command is outstanding.
REQ-018 On accept with cmd_addr[1:0]==0: capture addr/wdata/write and go to SETUP. Next cycle: PSEL=1, PENABLE=0.
REQ-019 On accept with cmd_addr[1:0]!=0: go directly to RESP with rsp_err=1, rsp_timeout=0 and rsp_rdata=0. PSEL SHALL never assert for that command.
REQ-020 SETUP SHALL last exactly one cycle and then go to ACCESS, where PSEL=1 and PENABLE=1.
REQ-021 PADDR, PWRITE and PWDATA SHALL stay stable from SETUP through the last ACCESS cycle.
REQ-022 PWDATA SHALL be 0 for reads.
REQ-023 In ACCESS, on a sampled PREADY=1:
- capture PRDATA (reads only, else 0) into rsp_rdata;
- capture PSLVERR into rsp_err;
- deassert PSEL/PENABLE next cycle;
- go to RESP.
REQ-024 An ACCESS wait counter SHALL clear on entry and increment on each cycle with PREADY=0.
REQ-025 When the wait counter reaches TIMEOUT_CYCLES-1 with PREADY=0, the block SHALL abort: PSEL/PENABLE low next cycle, RESP with rsp_err=1, rsp_timeout=1, rsp_rdata=0.
REQ-026 PREADY=1 on the timeout cycle SHALL win: normal completion, no timeout.
REQ-027 In RESP, rsp_valid SHALL be 1 and rsp_* SHALL be held stable until rsp_ready=1, then go to IDLE with rsp_valid=0 next cycle.
REQ-028 Aligned, zero-wait latency: accept at cycle N, SETUP N+1, ACCESS N+2, rsp_valid N+3, cmd_ready again one cycle after the rsp handshake.
REQ-029 PSEL=0 SHALL imply PENABLE=0 in every cycle.
REQ-030 PREADY, PSLVERR and PRDATA SHALL be ignored outside ACCESS.

Reset
REQ-031 With PRESET high at a PCLK edge, state SHALL become IDLE and these outputs SHALL be 0: PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_rdata, rsp_err, rsp_timeout.
REQ-032 cmd_ready SHALL be 0 while PRESET is high and 1 the first cycle after release.
REQ-033 Reset in any state, including mid-ACCESS, SHALL drop the transfer silently with no response generated.

Verification
REQ-034 Write 0x0C, data 0x83, PREADY tied 1 -> PSEL at N+1, PENABLE at N+2, rsp_valid at N+3 with rsp_err=0, rsp_rdata=0.
REQ-035 Read 0x14, PREADY low for 3 ACCESS cycles, PRDATA=0x60 -> PENABLE high for 4 cycles, PADDR stable, rsp_rdata=0x60.
REQ-036 Read with PSLVERR=1 at completion -> rsp_err=1, rsp_timeout=0; misaligned 0x0D -> rsp_err=1 and PSEL never high.
REQ-037 TIMEOUT_CYCLES=8, PREADY stuck 0 -> PENABLE high exactly 8 cycles, then rsp_err=1, rsp_timeout=1; PREADY=1 on cycle 8 -> normal completion.
REQ-038 rsp_ready held 0 for 5 cycles -> rsp_* stable and cmd_ready=0 throughout.
REQ-039 PRESET asserted mid-ACCESS -> all outputs 0 next cycle; cmd_ready=1 after release; no rsp_valid.
